alu_op_sequencer: RTL and testbench

- Issue/writeback stage directly upstream of the 8-bit ALU: accepts operation commands on a valid/ready handshake and reads two operands from a local register file.
- Drives the ALU's A, B and select inputs, captures the ALU's Result and Zero one cycle later, and writes Result back to the register file.
- Presents Result and Zero on a valid/ready response channel. One command is in flight at a time.

---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- issue/writeback stage in front of an 8-bit combinational ALU.
//
// Accepts one command at a time on a valid/ready channel. It reads both operands
// from a local register file, drives the ALU from registered outputs, captures
// Result/Zero one cycle later, writes Result back and presents it on a
// valid/ready response channel. FSM: IDLE -> EXEC -> RESP -> IDLE.
//
// Optional build macro: ALU_SEQ_FWD_EN. When it is defined, a load on ld_en in
// the accept cycle is forwarded to a matching source operand. When it is not
// defined, operands read the pre-edge register contents.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_src_a/b, cmd_dst    ALU select, operand register indices, destination
//   ld_en, ld_addr, ld_data         direct register load, honoured in every state
//   alu_a, alu_b, alu_sel           registered drive to the ALU
//   alu_result, alu_zero            ALU outputs (combinational from alu_*)
//   res_valid/res_ready             response handshake
//   res_data, res_zero, res_dst     captured result, zero flag, written register
module alu_op_sequencer #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  input  logic [AW-1:0] cmd_dst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic [AW-1:0] res_dst
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [DW-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            res_zero_q, res_zero_d;
  logic            res_valid_q, res_valid_d;
  logic [AW-1:0]   res_dst_q, res_dst_d;
  logic [DW-1:0]   opnd_a, opnd_b;
  logic            accept;

  // Ready is decoded from state so it rises in the first cycle after reset
  // release. It is gated by rst_n so that it stays low while reset is held.
  assign cmd_ready = rst_n & (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;

`ifdef ALU_SEQ_FWD_EN
  // Same-cycle load-to-use bypass.
  assign opnd_a = (ld_en && ld_addr == cmd_src_a) ? ld_data : regs_q[cmd_src_a];
  assign opnd_b = (ld_en && ld_addr == cmd_src_b) ? ld_data : regs_q[cmd_src_b];
`else
  assign opnd_a = regs_q[cmd_src_a];
  assign opnd_b = regs_q[cmd_src_b];
`endif

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    dst_d       = dst_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;
    res_dst_d   = res_dst_q;

    if (ld_en) regs_d[ld_addr] = ld_data;

    case (state_q)
      IDLE: if (accept) begin
        alu_a_d   = opnd_a;
        alu_b_d   = opnd_b;
        alu_sel_d = cmd_op;
        dst_d     = cmd_dst;
        state_d   = EXEC;
      end
      EXEC: begin
        // This assignment comes after the load, so the writeback wins a same-register collision.
        regs_d[dst_q] = alu_result;
        res_data_d    = alu_result;
        res_zero_d    = alu_zero;
        res_dst_d     = dst_q;
        res_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      regs_q      <= '{default: '0};
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      dst_q       <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      dst_q       <= dst_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
      res_dst_q   <= res_dst_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_valid = res_valid_q;
  assign res_dst   = res_dst_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. A small behavioural ALU stands in for
// the downstream unit. Its codes are 000 ADD, 001 SUB, 010 AND, 011 OR,
// 100 NOT A, and every other code returns 0. Register contents are read back
// through the design itself by issuing OR r,r -> r, which leaves r unchanged.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_zero;
  logic       res_valid, res_ready, res_zero;
  logic [7:0] res_data;
  logic [1:0] res_dst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(8), .NREG(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_dst(res_dst)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] d);
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_valid = 1'b1;
  endtask

  // Full transaction with res_ready high. It returns the captured response.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] d, output logic [7:0] data, output logic z);
    int n;
    @(negedge clk); set_cmd(op, sa, sb, d);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk); cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("resp_wait", {31'd0, res_valid}, 32'd1);
    chk("res_dst", {30'd0, res_dst}, {30'd0, d});
    data = res_data; z = res_zero;
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    logic z;
    run_cmd(3'b011, r, r, r, v, z);
  endtask

  // One command with a register load driven during its EXEC cycle.
  task automatic cmd_exec_ld(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] d, input logic [1:0] la, input logic [7:0] ldv,
                             output logic [7:0] data);
    @(negedge clk); set_cmd(op, sa, sb, d);
    @(negedge clk); cmd_valid = 1'b0; ld_en = 1'b1; ld_addr = la; ld_data = ldv;
    @(negedge clk); ld_en = 1'b0;
    chk("exec_ld_valid", {31'd0, res_valid}, 32'd1);
    data = res_data;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic       z;
    logic [7:0] fwd_exp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0;
    cmd_dst = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Load and add: 12 + 34 -> r2
    ld(2'd0, 8'h12); ld(2'd1, 8'h34);
    @(negedge clk); set_cmd(3'b000, 2'd0, 2'd1, 2'd2);
    @(negedge clk); cmd_valid = 1'b0;
    chk("add_alu_a", {24'd0, alu_a}, 32'h12);
    chk("add_alu_b", {24'd0, alu_b}, 32'h34);
    chk("add_alu_sel", {29'd0, alu_sel}, 32'd0);
    chk("add_exec_ready", {31'd0, cmd_ready}, 32'd0);
    chk("add_exec_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("add_res_valid", {31'd0, res_valid}, 32'd1);
    chk("add_res_data", {24'd0, res_data}, 32'h46);
    chk("add_res_zero", {31'd0, res_zero}, 32'd0);
    chk("add_res_dst", {30'd0, res_dst}, 32'd2);
    @(negedge clk);
    chk("add_back_idle", {31'd0, cmd_ready}, 32'd1);
    chk("add_valid_drop", {31'd0, res_valid}, 32'd0);
    read_reg(2'd2, v); chk("r2_after_add", {24'd0, v}, 32'h46);

    // Wrap to zero, then subtract to FF
    ld(2'd0, 8'hFF); ld(2'd1, 8'h01);
    run_cmd(3'b000, 2'd0, 2'd1, 2'd3, v, z);
    chk("wrap_data", {24'd0, v}, 32'h00); chk("wrap_zero", {31'd0, z}, 32'd1);
    run_cmd(3'b001, 2'd3, 2'd1, 2'd3, v, z);
    chk("sub_data", {24'd0, v}, 32'hFF); chk("sub_zero", {31'd0, z}, 32'd0);
    read_reg(2'd3, v); chk("r3_after_sub", {24'd0, v}, 32'hFF);

    // Backpressure: r1 = 01, ADD r1+r1 -> r1 held pending, then repeated
    @(negedge clk); res_ready = 1'b0; set_cmd(3'b000, 2'd1, 2'd1, 2'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", {24'd0, res_data}, 32'h02);
      chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_no_accept", {24'd0, alu_a}, 32'h01);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_valid_drop", {31'd0, res_valid}, 32'd0);
    @(negedge clk); cmd_valid = 1'b0;
    chk("bp_second_accept", {24'd0, alu_a}, 32'h02);
    chk("bp_second_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("bp_second_data", {24'd0, res_data}, 32'h04);
    @(negedge clk);

    // Collision: writeback beats a same-register load; other register loads
    ld(2'd0, 8'h0F);
    cmd_exec_ld(3'b011, 2'd0, 2'd0, 2'd2, 2'd2, 8'hAA, v);
    chk("coll_res", {24'd0, v}, 32'h0F);
    read_reg(2'd2, v); chk("coll_r2", {24'd0, v}, 32'h0F);
    cmd_exec_ld(3'b011, 2'd0, 2'd0, 2'd2, 2'd1, 8'hAA, v);
    read_reg(2'd1, v); chk("coll_r1", {24'd0, v}, 32'hAA);

    // Reserved op clears destination
    ld(2'd0, 8'h55);
    run_cmd(3'b110, 2'd0, 2'd0, 2'd3, v, z);
    chk("rsv_data", {24'd0, v}, 32'h00); chk("rsv_zero", {31'd0, z}, 32'd1);
    read_reg(2'd3, v); chk("rsv_r3", {24'd0, v}, 32'h00);

    // Same-cycle load plus NOT r0
`ifdef ALU_SEQ_FWD_EN
    fwd_exp = 8'hF8;
`else
    fwd_exp = 8'hAA;
`endif
    @(negedge clk); ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h07;
    set_cmd(3'b100, 2'd0, 2'd0, 2'd2);
    @(negedge clk); ld_en = 1'b0; cmd_valid = 1'b0;
    chk("fwd_alu_a", {24'd0, alu_a}, {24'd0, ~fwd_exp});
    @(negedge clk);
    chk("fwd_res", {24'd0, res_data}, {24'd0, fwd_exp});
    chk("fwd_zero", {31'd0, res_zero}, 32'd0);
    @(negedge clk);
    read_reg(2'd0, v); chk("fwd_r0", {24'd0, v}, 32'h07);

    // Reset during EXEC aborts the command and clears all state
    @(negedge clk); set_cmd(3'b000, 2'd1, 2'd1, 2'd0);
    @(negedge clk); cmd_valid = 1'b0;
    chk("pre_rst_alu_a", {24'd0, alu_a}, 32'hAA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("mid_rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      chk("rst_reg_clear", {24'd0, v}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
